mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns CPU load/store requests into word-wide
// memory port transactions, stalling the pipeline, aligning/extending load
// data and reporting misaligned, illegal and timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memDataSize,
    input  logic        memBitExtend,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;

    localparam logic [1:0] CODE_MISALIGNED = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT    = 2'd2;
    localparam logic [1:0] CODE_ILLEGAL    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } stateT;

    stateT            state;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic [1:0]       sizeQ;
    logic             extQ;
    logic [1:0]       offQ;

    logic             request;
    logic             illegal;
    logic             misaligned;
    logic [3:0]       byteenNext;
    logic [31:0]      wdataNext;
    logic [31:0]      shifted;
    logic [31:0]      loadValue;

    // Request classification from the live CPU inputs (only used in IDLE)
    assign request    = memRead | memWrite;
    assign illegal    = (memRead & memWrite) | (memDataSize == 2'd3);
    assign misaligned = ((memDataSize == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
                        ((memDataSize == SIZE_HALF) && addr[0]);

    // Pipeline hold: raised in the request cycle itself and for the whole access
    assign stall = ((state == IDLE) && request) || (state == ACCESS);

    assign waitCntNext = waitCnt + CNT_W'(1);

    // Lane enables and replicated store data for the accepted request
    always_comb begin
        byteenNext = 4'b0000;
        wdataNext  = wdata;
        case (memDataSize)
            SIZE_WORD: begin
                byteenNext = 4'b1111;
                wdataNext  = wdata;
            end
            SIZE_HALF: begin
                byteenNext = addr[1] ? 4'b1100 : 4'b0011;
                wdataNext  = {2{wdata[15:0]}};
            end
            SIZE_BYTE: begin
                byteenNext = 4'b0001 << addr[1:0];
                wdataNext  = {4{wdata[7:0]}};
            end
            default: begin
                byteenNext = 4'b0000;
                wdataNext  = wdata;
            end
        endcase
    end

    // Right-align returned lane data and extend it to 32 bits
    always_comb begin
        shifted   = mem_rdata >> {offQ, 3'b000};
        loadValue = shifted;
        case (sizeQ)
            SIZE_HALF: loadValue = extQ ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_BYTE: loadValue = extQ ? {24'h000000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            default:   loadValue = shifted;
        endcase
    end

    // Access FSM with registered memory-port, result and fault outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            sizeQ      <= 2'd0;
            extQ       <= 1'b0;
            offQ       <= 2'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_byteen <= 4'b0000;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            rdata      <= 32'h0000_0000;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (illegal) begin
                            fault_code <= CODE_ILLEGAL;
                            fault      <= 1'b1;
                            state      <= FAULT;
                        end else if (misaligned) begin
                            fault_code <= CODE_MISALIGNED;
                            fault      <= 1'b1;
                            state      <= FAULT;
                        end else begin
                            mem_en     <= 1'b1;
                            mem_we     <= memWrite;
                            mem_byteen <= byteenNext;
                            mem_addr   <= {addr[31:2], 2'b00};
                            mem_wdata  <= wdataNext;
                            sizeQ      <= memDataSize;
                            extQ       <= memBitExtend;
                            offQ       <= addr[1:0];
                            waitCnt    <= '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            rdata <= loadValue;
                        end
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        waitCnt <= waitCntNext;
                        if (waitCntNext == CNT_W'(MAX_WAIT)) begin
                            fault_code <= CODE_TIMEOUT;
                            fault      <= 1'b1;
                            mem_en     <= 1'b0;
                            mem_we     <= 1'b0;
                            state      <= FAULT;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-level reference memory model, a simple
// wait-state memory responder, and a scoreboard monitor fed by the driver.
module tb_mem_access_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [1:0]  memDataSize = 2'd0;
    logic        memBitExtend = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    mem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite),
        .memDataSize(memDataSize), .memBitExtend(memBitExtend),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .fault(fault), .fault_code(fault_code),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byteen(mem_byteen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isFault;
        logic [1:0]  code;
        logic [31:0] rdata;
    } respT;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  byteen;
        bit          we;
        logic [31:0] wdata;
    } accT;

    respT respQ[$];
    accT  accQ[$];

    int errors = 0;
    int checks = 0;

    logic [7:0]  refMem [0:1023];   // model view, byte addressed
    logic [31:0] memArr [0:255];    // physical memory behind the port
    logic [31:0] lastLoad = 32'h0;
    int          nextWait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: ready after nextWait idle cycles, applies lane writes
    int waitLeft = 0;
    bit respPrevEn = 1'b0;
    always @(negedge clk) begin
        if (!rst && mem_en) begin
            if (!respPrevEn) waitLeft = nextWait;
            if (waitLeft == 0) begin
                mem_ready = 1'b1;
                mem_rdata = memArr[mem_addr[9:2]];
                if (mem_we) begin
                    for (int k = 0; k < 4; k++)
                        if (mem_byteen[k]) memArr[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                waitLeft--;
            end
        end else begin
            mem_ready = 1'b0;
        end
        respPrevEn = !rst && mem_en;
    end

    // Scoreboard monitor: port contents during ACCESS, result at DONE/FAULT
    bit  monPrevEn = 1'b0;
    accT cur;
    respT r;
    always @(negedge clk) begin
        if (rst) begin
            monPrevEn = 1'b0;
        end else begin
            if (mem_en) begin
                if (!monPrevEn) begin
                    if (accQ.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access actual=mem_en required=none addr=%h", mem_addr);
                        cur = '{addr: mem_addr, byteen: mem_byteen, we: mem_we, wdata: mem_wdata};
                    end else begin
                        cur = accQ.pop_front();
                    end
                end
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_byteen", {28'h0, mem_byteen}, {28'h0, cur.byteen});
                chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (fault || (monPrevEn && !mem_en)) begin
                if (respQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_response actual=fault%0b required=none", fault);
                end else begin
                    r = respQ.pop_front();
                    chk("resp_is_fault", {31'h0, fault}, {31'h0, r.isFault});
                    if (r.isFault) chk("fault_code", {30'h0, fault_code}, {30'h0, r.code});
                    else           chk("rdata", rdata, r.rdata);
                end
            end
            monPrevEn = mem_en;
        end
    end

    // One CPU request: derive expectations, drive it, count stall cycles
    task automatic doTxn(input bit rd, input bit wr, input logic [1:0] size,
                         input bit ext, input logic [31:0] a, input logic [31:0] wd,
                         input int w);
        bit          isIllegal, isMis;
        int          n, expStall, cnt;
        logic [31:0] v, rep;
        logic [3:0]  be;
        isIllegal = (rd && wr) || (size == 2'd3);
        isMis = !isIllegal && (((size == 2'd0) && (a[1:0] != 2'b00)) || ((size == 2'd1) && a[0]));
        if (isIllegal) begin
            respQ.push_back('{isFault: 1'b1, code: 2'd3, rdata: 32'h0});
            expStall = 1;
        end else if (isMis) begin
            respQ.push_back('{isFault: 1'b1, code: 2'd1, rdata: 32'h0});
            expStall = 1;
        end else begin
            n   = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
            be  = 4'(((1 << n) - 1) << a[1:0]);
            rep = (n == 4) ? wd : (n == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
            accQ.push_back('{addr: {a[31:2], 2'b00}, byteen: be, we: wr, wdata: rep});
            if (w >= int'(MAX_WAIT)) begin
                respQ.push_back('{isFault: 1'b1, code: 2'd2, rdata: 32'h0});
                expStall = 1 + int'(MAX_WAIT);
            end else begin
                expStall = 2 + w;
                if (rd) begin
                    v = 32'h0;
                    for (int k = 0; k < n; k++) v[8*k +: 8] = refMem[a[9:0] + 10'(k)];
                    if (!ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                    lastLoad = v;
                end else begin
                    for (int k = 0; k < n; k++) refMem[a[9:0] + 10'(k)] = wd[8*k +: 8];
                end
                respQ.push_back('{isFault: 1'b0, code: 2'd0, rdata: lastLoad});
            end
        end
        nextWait = w;
        memRead = rd; memWrite = wr; memDataSize = size; memBitExtend = ext;
        addr = a; wdata = wd;
        #1;
        if (!stall) begin
            @(negedge clk); #1;
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            cnt++;
            if (cnt >= 2) begin
                memRead = 1'($urandom); memWrite = 1'($urandom);
                memDataSize = 2'($urandom); memBitExtend = 1'($urandom);
                addr = $urandom; wdata = $urandom;
            end
            @(negedge clk); #1;
        end
        chk("stall_cycles", 32'(cnt), 32'(expStall));
    endtask

    logic [31:0] word;
    initial begin
        for (int i = 0; i < 256; i++) begin
            word = $urandom;
            if (i == 32'h40) word = 32'h8001_1234;
            if (i == 32'h80) word = 32'hAB00_0000;
            memArr[i] = word;
            for (int k = 0; k < 4; k++) refMem[4*i + k] = word[8*k +: 8];
        end

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_byteen", {28'h0, mem_byteen}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_fault_code", {30'h0, fault_code}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Load half, sign-extended, zero wait
        doTxn(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 0);
        chk("load_half_rdata", rdata, 32'hFFFF_8001);
        // Load byte, zero-extended, three wait states
        doTxn(1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0203, 32'h0, 3);
        chk("load_byte_rdata", rdata, 32'h0000_00AB);
        // Store byte
        doTxn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0011, 32'h0000_005A, 0);
        chk("store_keeps_rdata", rdata, 32'h0000_00AB);
        // Misaligned word load
        doTxn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0, 0);
        // Illegal: both directions, and size 3
        doTxn(1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h0, 0);
        doTxn(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 0);
        // Wait boundaries: last cycle still succeeds, then exactly a timeout
        doTxn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0, int'(MAX_WAIT) - 1);
        doTxn(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, int'(MAX_WAIT));
        doTxn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0, 0);

        // Reset in the middle of a store access: aborted, nothing written
        accQ.push_back('{addr: 32'h0000_0080, byteen: 4'hF, we: 1'b1, wdata: 32'h1234_5678});
        nextWait = 30;
        memRead = 1'b0; memWrite = 1'b1; memDataSize = 2'd0; addr = 32'h80; wdata = 32'h1234_5678;
        #1;
        if (!stall) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_access_mem_en", {31'h0, mem_en}, 32'h0);
        memWrite = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_stall", {31'h0, stall}, 32'h0);
        chk("post_rst_rdata", rdata, 32'h0);
        chk("abort_no_write", memArr[32], {refMem[131], refMem[130], refMem[129], refMem[128]});
        lastLoad = 32'h0;
        @(negedge clk); #1;

        // Randomized back-to-back traffic
        for (int t = 0; t < 200; t++) begin
            bit rd, wr, ext;
            logic [1:0] size;
            logic [31:0] a;
            int sel, w;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4) || (sel == 9);
            wr  = (sel >= 5);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ext = 1'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                if (size == 2'd0) a[1:0] = 2'b00;
                if (size == 2'd1) a[0] = 1'b0;
            end
            w = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 3) : $urandom_range(12, 17);
            doTxn(rd, wr, size, ext, a, $urandom, w);
        end

        memRead = 1'b0; memWrite = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("resp_queue_empty", 32'(respQ.size()), 32'h0);
        chk("acc_queue_empty", 32'(accQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
